// File: rtl/maze_bram_writer_pkg.sv
// Shared maze constants: grid geometry, cell word encoding
// and the writer FSM state type.
package maze_bram_writer_pkg;

    localparam int GRID_W = 16;
    localparam int ADDR_W = 8;
    localparam int WORD_W = 9;
    localparam int WALL_BIT = 0;
    localparam logic [WORD_W-1:0] WALL_WORD = 9'h001;
    localparam logic [WORD_W-1:0] PATH_WORD = 9'h000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_CMD_WR,
        ST_FINISH
    } wr_state_e;

endpackage

// File: rtl/maze_bram_writer_if.sv
// Single-cell command handshake plus the BRAM write port.
// slave = writer side, master = requester/observer side.
interface maze_bram_writer_if;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [8:0] cmd_data;
    logic       cmd_ready;
    logic       bram_we;
    logic [7:0] bram_addr;
    logic [8:0] bram_din;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data,
        output cmd_ready, bram_we, bram_addr, bram_din
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_data,
        input  cmd_ready, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/maze_border_check.sv
// Flags cells on the outer ring of a square power-of-two grid.
module maze_border_check #(
    parameter int GRID_W = 16
) (
    input  logic [7:0] addr,
    output logic       is_border
);
    localparam int XW = $clog2(GRID_W);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [7-XW:0] YMAX = (8 - XW)'(GRID_W - 1);

    logic [XW-1:0] x;
    logic [7-XW:0] y;

    assign x = addr[XW-1:0];
    assign y = addr[7:XW];
    assign is_border = (x == '0) || (x == XMAX) ||
                       (y == '0) || (y == YMAX);
endmodule

// File: rtl/maze_bram_writer.sv
// Streams a fresh maze into BRAM one cell per cycle and
// services single-cell overwrites while idle.
import maze_bram_writer_pkg::*;

module maze_bram_writer #(
    parameter int GRID_W     = maze_bram_writer_pkg::GRID_W,
    parameter int DEPTH      = 256,
    parameter int START_ADDR = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] density,
    input  logic [7:0] random_byte,
    output logic       busy,
    output logic       done,
    output logic [8:0] path_count,
    maze_bram_writer_if.slave bus
);
    wr_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [8:0] din_q, din_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [8:0] pc_q, pc_d;
    logic       is_border;
    logic [8:0] fill_word;

    maze_border_check #(.GRID_W(GRID_W)) u_border (
        .addr      (cnt_q),
        .is_border (is_border)
    );

    // The start cell is forced open so the spawner always has a seat.
    always_comb begin
        if (cnt_q == 8'(START_ADDR))
            fill_word = PATH_WORD;
        else if (is_border)
            fill_word = WALL_WORD;
        else if (random_byte < density)
            fill_word = WALL_WORD;
        else
            fill_word = PATH_WORD;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pc_d    = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                end else if (bus.cmd_valid) begin
                    state_d = ST_CMD_WR;
                    we_d    = 1'b1;
                    addr_d  = bus.cmd_addr;
                    din_d   = bus.cmd_data;
                    busy_d  = 1'b1;
                end
            end
            ST_FILL: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                din_d  = fill_word;
                cnt_d  = cnt_q + 8'd1;
                if (fill_word == PATH_WORD && pc_q != '1)
                    pc_d = pc_q + 9'd1;
                if (cnt_q == 8'(DEPTH - 1))
                    state_d = ST_FINISH;
            end
            ST_CMD_WR: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE) && !start;
    assign bus.bram_we   = we_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign path_count    = pc_q;
endmodule
